sgpio_led_drv: RTL and testbench



---
 rtl/sgpio_led_drv_pkg.sv | 22 ++
 rtl/sgpio_led_tick.sv | 75 +++++++
 rtl/sgpio_led_drv.sv | 128 ++++++++++++
 tb/tb_sgpio_led_drv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sgpio_led_drv_pkg.sv
// Shared types and default constants for the SGPIO LED pattern generator.
// CLK_KHZ default matches the clock the SGPIO receiver timeout is based on.
package sgpio_led_drv_pkg;

    typedef enum logic [1:0] {
        LED_OFF,
        LED_ON,
        LED_SLOW,
        LED_FAST
    } led_mode_e;

    localparam int DEF_CLK_KHZ      = 25000;
    localparam int DEF_FAST_HALF_MS = 125;
    localparam int DEF_SLOW_HALF_MS = 500;
    localparam int DEF_ACT_HOLD_MS  = 50;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sgpio_led_tick.sv
// Shared time base: millisecond prescaler plus fast/slow blink phase counters.
// Both phases come out of reset in the on phase so all drives blink together.
module sgpio_led_tick
    import sgpio_led_drv_pkg::*;
#(
    parameter int CLK_KHZ      = DEF_CLK_KHZ,
    parameter int FAST_HALF_MS = DEF_FAST_HALF_MS,
    parameter int SLOW_HALF_MS = DEF_SLOW_HALF_MS
) (
    input  logic clk,
    input  logic rst,
    output logic ms_tick_o,
    output logic fast_ph_o,
    output logic slow_ph_o
);

    localparam int PW = cnt_width(CLK_KHZ - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          ms_tick;
    logic [1:0]    ph;

    assign ms_tick = (pre_q == PW'(CLK_KHZ - 1));
    assign pre_d   = ms_tick ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Index 0 is the fast (locate) phase, index 1 the slow (rebuild) phase.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_phase
            localparam int HALF = (gi == 0) ? FAST_HALF_MS : SLOW_HALF_MS;
            localparam int W    = cnt_width(HALF - 1);

            logic [W-1:0] cnt_q, cnt_d;
            logic         ph_q, ph_d;

            always_comb begin
                cnt_d = cnt_q;
                ph_d  = ph_q;
                if (ms_tick) begin
                    if (cnt_q == W'(HALF - 1)) begin
                        cnt_d = '0;
                        ph_d  = ~ph_q;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                    ph_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_d;
                    ph_q  <= ph_d;
                end
            end

            assign ph[gi] = ph_q;
        end
    endgenerate

    assign ms_tick_o = ms_tick;
    assign fast_ph_o = ph[0];
    assign slow_ph_o = ph[1];

endmodule

// File: rtl/sgpio_led_drv.sv
// Per-drive activity/status LED driver fed by the SGPIO receiver levels.
// Define SGPIO_LED_ACT_STRETCH_EN to add the activity afterglow hold counters.
module sgpio_led_drv
    import sgpio_led_drv_pkg::*;
#(
    parameter int Drive_num    = 4,
    parameter int CLK_KHZ      = DEF_CLK_KHZ,
    parameter int FAST_HALF_MS = DEF_FAST_HALF_MS,
    parameter int SLOW_HALF_MS = DEF_SLOW_HALF_MS,
    parameter int ACT_HOLD_MS  = DEF_ACT_HOLD_MS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [Drive_num-1:0] drive_fault,
    input  logic [Drive_num-1:0] drive_active,
    input  logic [Drive_num-1:0] drive_rebuild,
    input  logic [Drive_num-1:0] drive_locate,
    output logic [Drive_num-1:0] led_act_n,
    output logic [Drive_num-1:0] led_stat_n
);

    logic                 ms_tick;
    logic                 fast_ph;
    logic                 slow_ph;
    logic [Drive_num-1:0] green;
    logic [Drive_num-1:0] amber;
    logic [Drive_num-1:0] led_act_q;
    logic [Drive_num-1:0] led_stat_q;

    sgpio_led_tick #(
        .CLK_KHZ      (CLK_KHZ),
        .FAST_HALF_MS (FAST_HALF_MS),
        .SLOW_HALF_MS (SLOW_HALF_MS)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .ms_tick_o (ms_tick),
        .fast_ph_o (fast_ph),
        .slow_ph_o (slow_ph)
    );

`ifndef SGPIO_LED_ACT_STRETCH_EN
    logic unused_ok;
    assign unused_ok = &{1'b0, ms_tick, ACT_HOLD_MS[0]};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < Drive_num; gi++) begin : g_drv
            logic      lamp;
            logic      amber_bit;
            led_mode_e mode;

            // All-ones is the receiver's reset/timeout pattern: lamp test.
            assign lamp = drive_fault[gi] & drive_active[gi]
                        & drive_rebuild[gi] & drive_locate[gi];

            always_comb begin
                mode = LED_OFF;
                if (lamp || drive_fault[gi]) begin
                    mode = LED_ON;
                end else if (drive_rebuild[gi]) begin
                    mode = LED_SLOW;
                end else if (drive_locate[gi]) begin
                    mode = LED_FAST;
                end
            end

            always_comb begin
                amber_bit = 1'b0;
                case (mode)
                    LED_ON:   amber_bit = 1'b1;
                    LED_SLOW: amber_bit = slow_ph;
                    LED_FAST: amber_bit = fast_ph;
                    default:  amber_bit = 1'b0;
                endcase
            end

            assign amber[gi] = amber_bit;

`ifdef SGPIO_LED_ACT_STRETCH_EN
            localparam int HW = cnt_width(ACT_HOLD_MS);

            logic          act_q;
            logic [HW-1:0] hold_q, hold_d;

            // A falling edge reload takes precedence over a coincident ms_tick.
            always_comb begin
                hold_d = hold_q;
                if (act_q && !drive_active[gi]) begin
                    hold_d = HW'(ACT_HOLD_MS);
                end else if (ms_tick && (hold_q != '0)) begin
                    hold_d = hold_q - HW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    act_q  <= 1'b0;
                    hold_q <= '0;
                end else begin
                    act_q  <= drive_active[gi];
                    hold_q <= hold_d;
                end
            end

            // Using the next-state count keeps the LED lit through the fall cycle.
            assign green[gi] = lamp | drive_active[gi] | (hold_d != '0);
`else
            assign green[gi] = lamp | drive_active[gi];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_act_q  <= '0;
            led_stat_q <= '0;
        end else begin
            led_act_q  <= ~green;
            led_stat_q <= ~amber;
        end
    end

    assign led_act_n  = led_act_q;
    assign led_stat_n = led_stat_q;

endmodule

// File: tb/tb_sgpio_led_drv.sv
// Scoreboard bench for sgpio_led_drv: stimulus pushes expected pins, a monitor pops and compares.
// Expected values come from a time-based model (edge index arithmetic), for either build of the stretch option.
module tb_sgpio_led_drv;

    localparam int N = 4;
    localparam int K = 4;
    localparam int F = 3;
    localparam int S = 6;
    localparam int H = 5;

`ifdef SGPIO_LED_ACT_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] fault = '0;
    logic [N-1:0] active = '0;
    logic [N-1:0] rebuild = '0;
    logic [N-1:0] locate = '0;
    logic [N-1:0] led_act_n;
    logic [N-1:0] led_stat_n;

    always #5 clk = ~clk;

    sgpio_led_drv #(
        .Drive_num    (N),
        .CLK_KHZ      (K),
        .FAST_HALF_MS (F),
        .SLOW_HALF_MS (S),
        .ACT_HOLD_MS  (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .drive_fault   (fault),
        .drive_active  (active),
        .drive_rebuild (rebuild),
        .drive_locate  (locate),
        .led_act_n     (led_act_n),
        .led_stat_n    (led_stat_n)
    );

    typedef struct {
        int           n;
        logic [N-1:0] act_n;
        logic [N-1:0] stat_n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_cnt = 0;

    logic [N-1:0] prev_act = '0;
    int           last_fall[N];

    always @(posedge clk) begin
        if (rst) edge_cnt <= edge_cnt + 1;
    end

    // Blink level seen on the pin after edge n: the phase flips every half*K edges.
    function automatic bit phase_on(input int n, input int half);
        return (((n - 1) / (half * K)) % 2) == 0;
    endfunction

    // Drive inputs for the next edge and queue the pins expected just after it.
    task automatic apply(input logic [N-1:0] f, input logic [N-1:0] a,
                         input logic [N-1:0] r, input logic [N-1:0] l);
        exp_t e;
        int   n;
        bit   lamp, amb, glow;
        n = edge_cnt + 1;
        fault = f; active = a; rebuild = r; locate = l;
        e.n = n;
        for (int d = 0; d < N; d++) begin
            lamp = f[d] & a[d] & r[d] & l[d];
            if (lamp || f[d])   amb = 1'b1;
            else if (r[d])      amb = phase_on(n, S);
            else if (l[d])      amb = phase_on(n, F);
            else                amb = 1'b0;
            if (prev_act[d] && !a[d]) last_fall[d] = n;
            glow = STRETCH && (last_fall[d] >= 0) && ((n / K - last_fall[d] / K) < H);
            e.act_n[d]  = ~(lamp | a[d] | glow);
            e.stat_n[d] = ~amb;
            prev_act[d] = a[d];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            if (sb[0].n == edge_cnt) begin
                mon_e = sb.pop_front();
                vectors++;
                if (led_act_n !== mon_e.act_n || led_stat_n !== mon_e.stat_n) begin
                    miscompares++;
                    $display("FAIL pins edge %0d: led_act_n=%b led_stat_n=%b, expected %b %b",
                             mon_e.n, led_act_n, led_stat_n, mon_e.act_n, mon_e.stat_n);
                end else begin
                    $display("edge %0d ok: led_act_n=%b led_stat_n=%b", mon_e.n, led_act_n, led_stat_n);
                end
            end else if (sb[0].n < edge_cnt) begin
                mon_e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed edge %0d: monitor at edge %0d, required %0d", mon_e.n, edge_cnt, mon_e.n);
            end
        end
    end

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] f, a, r, l;
        for (int d = 0; d < N; d++) last_fall[d] = -1;

        // Reset held: every pin lit.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (led_act_n !== '0 || led_stat_n !== '0) begin
                miscompares++;
                $display("FAIL reset pins: led_act_n=%b led_stat_n=%b, required 0000 0000", led_act_n, led_stat_n);
            end else begin
                $display("reset ok: led_act_n=%b led_stat_n=%b", led_act_n, led_stat_n);
            end
        end
        rst = 1'b1;

        // Directed: fault, locate->rebuild->fault escalation, activity pulses, lamp mid-blink.
        for (int c = 1; c <= 240; c++) begin
            f = 4'b0001;
            l = 4'b1010;
            r = 4'b0000;
            a = 4'b0000;
            if (c >= 60)  r[1] = 1'b1;
            if (c >= 120) f[1] = 1'b1;
            a[2] = (c == 10) || (c == 18) || (c == 80);
            if (c >= 31 && c < 36) begin
                f[3] = 1'b1; a[3] = 1'b1; r[3] = 1'b1; l[3] = 1'b1;
            end else if (c >= 36 && c < 40) begin
                l[3] = 1'b0;
            end
            apply(f, a, r, l);
        end

        // Randomized: slow-changing status levels, busy activity, occasional lamp/clear.
        f = '0; a = '0; r = '0; l = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 31) == 0) f[d] = ~f[d];
                if ($urandom_range(0, 31) == 0) r[d] = ~r[d];
                if ($urandom_range(0, 31) == 0) l[d] = ~l[d];
                if ($urandom_range(0, 2) == 0)  a[d] = ~a[d];
                case ($urandom_range(0, 49))
                    0: begin f[d] = 1'b1; a[d] = 1'b1; r[d] = 1'b1; l[d] = 1'b1; end
                    1: begin f[d] = 1'b0; a[d] = 1'b0; r[d] = 1'b0; l[d] = 1'b0; end
                    default: ;
                endcase
            end
            apply(f, a, r, l);
        end

        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end else begin
            $display("scoreboard drained");
        end

        // Asynchronous reset mid-cycle must light every pin before any clock edge.
        active = '0; fault = '0; rebuild = '0; locate = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (led_act_n !== '0 || led_stat_n !== '0) begin
            miscompares++;
            $display("FAIL async reset: led_act_n=%b led_stat_n=%b, required 0000 0000", led_act_n, led_stat_n);
        end else begin
            $display("async reset ok: led_act_n=%b led_stat_n=%b", led_act_n, led_stat_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
